// File: rtl/led_page_sequencer_pkg.sv
// Shared definitions for the LED page sequencer: page/offset/address widths,
// default channel count, FSM state encodings and the effective-end helper.
package led_page_sequencer_pkg;

  localparam int PAGE_W      = 7;
  localparam int OFF_W       = 6;
  localparam int ADDR_W      = PAGE_W + OFF_W;
  localparam int LED_NUM_DEF = 16;

  localparam logic [PAGE_W-1:0] PAGE_MAX = 7'h7F;

  // FSM encodings, also presented on the debug state output.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  // An end page below the start page collapses to a single-page sequence.
  function automatic logic [PAGE_W-1:0] eff_end_page(input logic [PAGE_W-1:0] start_pg,
                                                     input logic [PAGE_W-1:0] end_pg);
    return (end_pg < start_pg) ? start_pg : end_pg;
  endfunction

endpackage

// File: rtl/led_seq_frame_timer.sv
// Frame timer: counts timebase ticks while enabled and raises due_o on the
// tick that completes a frame period of frame_div_i+1 ticks.
module led_seq_frame_timer #(
  parameter int FDIV_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              tick_i,
  input  logic [FDIV_W-1:0] frame_div_i,
  output logic              due_o
);

  logic [FDIV_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a live shrink of the divider cannot strand the count.
  assign due_o = en_i && tick_i && (cnt_q >= frame_div_i);

  // Next count: clear on request or at frame end, otherwise step on each tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || due_o) begin
      cnt_d = '0;
    end else if (en_i && tick_i) begin
      cnt_d = cnt_q + FDIV_W'(1);
    end
  end

  // Tick counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_page_sequencer.sv
// LED page sequencer: fetches one page of duties from the PWM RAM into a
// shadow buffer, commits it atomically to duty_o, then waits a frame period.
// Optional build macro: LED_SEQ_PINGPONG_EN (bounce between start and end
// page instead of wrapping when looping).
module led_page_sequencer
  import led_page_sequencer_pkg::*;
#(
  parameter int LED_NUM = LED_NUM_DEF,
  parameter int RD_LAT  = 1,
  parameter int FDIV_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_i,
  input  logic                 tick_i,
  input  logic [PAGE_W-1:0]    cfg_start_page,
  input  logic [PAGE_W-1:0]    cfg_end_page,
  input  logic [FDIV_W-1:0]    cfg_frame_div,
  input  logic                 cfg_loop,
  output logic [ADDR_W-1:0]    rd_addr_o,
  input  logic [7:0]           rd_data_i,
  output logic [LED_NUM*8-1:0] duty_o,
  output logic                 duty_load_o,
  output logic [PAGE_W-1:0]    cur_page_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           dbg_state_o
);

  localparam int FCNT_W = 7;
  localparam logic [FCNT_W-1:0] FETCH_LAST = FCNT_W'(LED_NUM + RD_LAT - 1);

  logic [1:0]           state_q, state_d;
  logic [PAGE_W-1:0]    page_q, page_d;
  logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 done_q, done_d;
  logic [LED_NUM*8-1:0] duty_q;
  logic [PAGE_W-1:0]    cur_page_q;
  logic [7:0]           shadow_q [LED_NUM];

  logic                 timer_clr, frame_due, commit_en, cap_en, at_end;
  logic [FCNT_W-1:0]    cap_idx;
  logic [PAGE_W-1:0]    eff_end;
`ifdef LED_SEQ_PINGPONG_EN
  logic                 dir_q, dir_d;   // 1 = ascending
`endif

  // duty_o/duty_load_o contract: duty_load_o is high for exactly the one
  // cycle whose closing edge loads duty_o and cur_page_o with the new frame;
  // there is no back-pressure, the consumer must take it on that edge.
  assign commit_en   = (state_q == ST_COMMIT) && run_i;
  assign duty_load_o = commit_en;
  assign duty_o      = duty_q;
  assign cur_page_o  = cur_page_q;
  assign rd_addr_o   = addr_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign dbg_state_o = state_q;

  // Read data for offset n arrives RD_LAT cycles after its address.
  assign cap_en  = (state_q == ST_FETCH) && (fcnt_q >= FCNT_W'(RD_LAT));
  assign cap_idx = fcnt_q - FCNT_W'(RD_LAT);
  assign eff_end = eff_end_page(cfg_start_page, cfg_end_page);
  // 127 is treated as an end so page arithmetic never wraps to 0.
  assign at_end  = (page_q == eff_end) || (page_q == PAGE_MAX);

  led_seq_frame_timer #(.FDIV_W(FDIV_W)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (timer_clr),
    .en_i        (state_q == ST_WAIT),
    .tick_i      (tick_i),
    .frame_div_i (cfg_frame_div),
    .due_o       (frame_due)
  );

  // Sequencer FSM next-state, read addressing and page advance.
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    fcnt_d    = fcnt_q;
    addr_d    = addr_q;
    done_d    = done_q;
    timer_clr = 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
    dir_d     = dir_q;
`endif
    if (!run_i) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!done_q) begin
            page_d    = cfg_start_page;
            fcnt_d    = '0;
            addr_d    = {cfg_start_page, {OFF_W{1'b0}}};
            timer_clr = 1'b1;
            state_d   = ST_FETCH;
`ifdef LED_SEQ_PINGPONG_EN
            dir_d     = 1'b1;
`endif
          end
        end
        ST_FETCH: begin
          if (fcnt_q < FCNT_W'(LED_NUM - 1)) begin
            addr_d = {page_q, OFF_W'(fcnt_q + FCNT_W'(1))};
          end
          if (fcnt_q == FETCH_LAST) begin
            state_d = ST_COMMIT;
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
        end
        ST_COMMIT: begin
          state_d = ST_WAIT;
`ifdef LED_SEQ_PINGPONG_EN
          if (dir_q) begin
            if (!at_end) begin
              page_d = page_q + 7'd1;
            end else if (cfg_loop) begin
              if (eff_end == cfg_start_page) begin
                page_d = cfg_start_page;
              end else begin
                page_d = page_q - 7'd1;
                dir_d  = 1'b0;
              end
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            if (page_q > cfg_start_page) begin
              page_d = page_q - 7'd1;
            end else begin
              dir_d  = 1'b1;
              page_d = (eff_end != cfg_start_page) ? cfg_start_page + 7'd1 : cfg_start_page;
            end
          end
`else
          if (!at_end) begin
            page_d = page_q + 7'd1;
          end else if (cfg_loop) begin
            page_d = cfg_start_page;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
`endif
        end
        default: begin
          if (frame_due) begin
            fcnt_d  = '0;
            addr_d  = {page_q, {OFF_W{1'b0}}};
            state_d = ST_FETCH;
          end
        end
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      page_q  <= '0;
      fcnt_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      fcnt_q  <= fcnt_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

`ifdef LED_SEQ_PINGPONG_EN
  // Sweep direction register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= 1'b1;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  // Shadow capture during fetch and atomic commit to the duty outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q     <= '0;
      cur_page_q <= '0;
      for (int k = 0; k < LED_NUM; k++) shadow_q[k] <= 8'h00;
    end else begin
      for (int k = 0; k < LED_NUM; k++) begin
        if (cap_en && (cap_idx == FCNT_W'(k))) shadow_q[k] <= rd_data_i;
      end
      if (commit_en) begin
        for (int k = 0; k < LED_NUM; k++) duty_q[8*k +: 8] <= shadow_q[k];
        cur_page_q <= page_q;
      end
    end
  end

endmodule

// File: tb/tb_led_page_sequencer.sv
// Testbench for led_page_sequencer: RAM model preloaded with page p, LED k =
// p*16+k; directed scenarios push expected committed pages into a queue and a
// negedge monitor checks each commit. Honours LED_SEQ_PINGPONG_EN if defined.
module tb_led_page_sequencer;
  import led_page_sequencer_pkg::*;

  localparam int LED_NUM  = 16;
  localparam int RD_LAT   = 1;
  localparam int FDIV_W   = 16;
  localparam int DW       = LED_NUM * 8;
  localparam int TICK_PER = 30;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run_i = 1'b0;
  logic              tick_i = 1'b0;
  logic [6:0]        cfg_start_page = '0;
  logic [6:0]        cfg_end_page = '0;
  logic [FDIV_W-1:0] cfg_frame_div = '0;
  logic              cfg_loop = 1'b0;
  logic [12:0]       rd_addr_o;
  logic [7:0]        rd_data_i = '0;
  logic [DW-1:0]     duty_o;
  logic              duty_load_o;
  logic [6:0]        cur_page_o;
  logic              busy_o;
  logic              done_o;
  logic [1:0]        dbg_state_o;

  always #5 clk = ~clk;

  led_page_sequencer #(.LED_NUM(LED_NUM), .RD_LAT(RD_LAT), .FDIV_W(FDIV_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .run_i          (run_i),
    .tick_i         (tick_i),
    .cfg_start_page (cfg_start_page),
    .cfg_end_page   (cfg_end_page),
    .cfg_frame_div  (cfg_frame_div),
    .cfg_loop       (cfg_loop),
    .rd_addr_o      (rd_addr_o),
    .rd_data_i      (rd_data_i),
    .duty_o         (duty_o),
    .duty_load_o    (duty_load_o),
    .cur_page_o     (cur_page_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .dbg_state_o    (dbg_state_o)
  );

  // RAM read port, one cycle latency.
  logic [7:0] mem [0:8191];
  always @(posedge clk) rd_data_i <= mem[rd_addr_o];

  // 1-clk timebase pulse every TICK_PER clocks.
  initial begin
    forever begin
      repeat (TICK_PER - 1) @(posedge clk);
      #1 tick_i = 1'b1;
      @(posedge clk);
      #1 tick_i = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  int         errors = 0;
  int         checks = 0;
  logic [6:0] exp_q[$];
  logic       chk_pending = 1'b0;
  logic [6:0] pend_page = '0;
  int         ticks_since_load = 0;
  logic       seen_load = 1'b0;
  int         exp_ticks = 3;
  int         load_cnt = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_frame(input logic [6:0] p);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < LED_NUM; k++) v[8*k +: 8] = 8'((int'(p) * 16 + k) & 255);
    return v;
  endfunction

  // Monitor: on a load, pop the expected page; check outputs one cycle later.
  always @(negedge clk) begin
    if (chk_pending) begin
      chk_pending = 1'b0;
      check("cur_page", DW'(cur_page_o), DW'(pend_page));
      check("duty", duty_o, exp_frame(pend_page));
    end
    if (duty_load_o) begin
      load_cnt++;
      if (seen_load) check("tick_spacing", DW'(ticks_since_load), DW'(exp_ticks));
      seen_load = 1'b1;
      ticks_since_load = 0;
      if (exp_q.size() == 0) begin
        check("unexpected_load", DW'(duty_load_o), DW'(0));
      end else begin
        pend_page   = exp_q.pop_front();
        chk_pending = 1'b1;
      end
    end else if (tick_i) begin
      ticks_since_load++;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || chk_pending) && n < max_cyc) begin
      nedge();
      n++;
    end
    check("drain_timeout", DW'(exp_q.size()), DW'(0));
  endtask

  task automatic wait_state(input logic [1:0] st, input int max_cyc);
    int n;
    n = 0;
    while (dbg_state_o != st && n < max_cyc) begin
      nedge();
      n++;
    end
    check("state_timeout", DW'(dbg_state_o), DW'(st));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int loads_before;
    for (int a = 0; a < 8192; a++) mem[a] = 8'((((a >> 6) * 16) + (a & 63)) & 255);

    // Reset state.
    nedge();
    nedge();
    check("rst_duty", duty_o, DW'(0));
    check("rst_busy", DW'(busy_o), DW'(0));
    check("rst_done", DW'(done_o), DW'(0));
    check("rst_addr", DW'(rd_addr_o), DW'(0));
    check("rst_page", DW'(cur_page_o), DW'(0));
    check("rst_load", DW'(duty_load_o), DW'(0));
    rst = 1'b0;
    nedge();

    // Pages 3..5 looping, 3 ticks per frame.
    cfg_start_page = 7'd3;
    cfg_end_page   = 7'd5;
    cfg_frame_div  = 16'd2;
    cfg_loop       = 1'b1;
    exp_ticks      = 3;
    seen_load      = 1'b0;
    exp_q.push_back(7'd3);
    exp_q.push_back(7'd4);
    exp_q.push_back(7'd5);
    exp_q.push_back(7'd3);
    run_i = 1'b1;
    wait_state(ST_FETCH, 10);
    // First FETCH cycle: addresses 0x0C0..0x0CF, load 17 cycles later.
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (i < LED_NUM) check("rd_addr", DW'(rd_addr_o), DW'(192 + i));
      if (duty_load_o) begin
        lat = i;
        break;
      end
      nedge();
    end
    check("load_latency", DW'(lat), DW'(17));
    wait_drain(1000);

    // Drop run at offset 7 of the page-4 fetch.
    wait_state(ST_FETCH, 200);
    repeat (7) nedge();
    check("abort_addr", DW'(rd_addr_o), DW'(13'h107));
    loads_before = load_cnt;
    run_i = 1'b0;
    nedge();
    check("abort_busy", DW'(busy_o), DW'(0));
    check("abort_state", DW'(dbg_state_o), DW'(ST_IDLE));
    repeat (20) nedge();
    check("abort_noload", DW'(load_cnt - loads_before), DW'(0));
    check("abort_duty", duty_o, exp_frame(7'd3));
    check("abort_page", DW'(cur_page_o), DW'(3));

    // Reset while fetching clears everything.
    run_i = 1'b1;
    wait_state(ST_FETCH, 10);
    repeat (5) nedge();
    rst   = 1'b1;
    run_i = 1'b0;
    nedge();
    check("fetch_rst_duty", duty_o, DW'(0));
    check("fetch_rst_busy", DW'(busy_o), DW'(0));
    check("fetch_rst_addr", DW'(rd_addr_o), DW'(0));
    check("fetch_rst_done", DW'(done_o), DW'(0));
    rst = 1'b0;
    nedge();

    // Pages 10..11 without loop: two commits then done.
    cfg_start_page = 7'd10;
    cfg_end_page   = 7'd11;
    cfg_frame_div  = 16'd0;
    cfg_loop       = 1'b0;
    exp_ticks      = 1;
    seen_load      = 1'b0;
    exp_q.push_back(7'd10);
    exp_q.push_back(7'd11);
    run_i = 1'b1;
    wait_drain(500);
    check("done_set", DW'(done_o), DW'(1));
    check("done_busy", DW'(busy_o), DW'(0));
    repeat (100) nedge();
    check("done_hold", DW'(done_o), DW'(1));
    check("done_hold_busy", DW'(busy_o), DW'(0));
    run_i = 1'b0;
    nedge();
    check("done_clear", DW'(done_o), DW'(0));
    seen_load = 1'b0;
    exp_q.push_back(7'd10);
    exp_q.push_back(7'd11);
    run_i = 1'b1;
    wait_drain(500);
    check("done_again", DW'(done_o), DW'(1));
    run_i = 1'b0;
    nedge();

    // End below start: only page 20 (LED0 = 0x40) is committed.
    cfg_start_page = 7'd20;
    cfg_end_page   = 7'd8;
    cfg_loop       = 1'b1;
    seen_load      = 1'b0;
    exp_q.push_back(7'd20);
    exp_q.push_back(7'd20);
    exp_q.push_back(7'd20);
    run_i = 1'b1;
    wait_drain(500);
    run_i = 1'b0;
    nedge();
    check("single_busy", DW'(busy_o), DW'(0));

    // Pages 1..3 looping.
    cfg_start_page = 7'd1;
    cfg_end_page   = 7'd3;
    seen_load      = 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
    exp_q.push_back(7'd1);
    exp_q.push_back(7'd2);
    exp_q.push_back(7'd3);
    exp_q.push_back(7'd2);
    exp_q.push_back(7'd1);
    exp_q.push_back(7'd2);
`else
    exp_q.push_back(7'd1);
    exp_q.push_back(7'd2);
    exp_q.push_back(7'd3);
    exp_q.push_back(7'd1);
    exp_q.push_back(7'd2);
`endif
    run_i = 1'b1;
    wait_drain(800);
    run_i = 1'b0;
    repeat (5) nedge();
    check("final_idle", DW'(busy_o), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
